soml_metric_argmin: RTL

- Downstream consumer of the Y·col inner-product stage in the SOML decoder.
- Takes its stream of signed Q8.8 real sums, grouped one group per candidate symbol.
- Squares and accumulates each group into a candidate metric, then tracks the minimum metric and its candidate index over NUM_CAND candidates.
- Reports the winning index with a one-cycle done pulse; the result feeds the symbol-decision logic.

---
 rtl/soml_pkg.sv | 18 +
 rtl/soml_sq_stage.sv | 43 ++++
 rtl/soml_metric_argmin.sv | 131 +++++++++++++
 3 files changed

// File: rtl/soml_pkg.sv
// rtl/soml_pkg.sv - shared constants and FSM state type for the SOML metric/argmin block
package soml_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC      = 8;
    localparam int ACC_W_MAX = 64;

    // All-ones saturation value; the top slices it down to its own ACC_W.
    localparam logic [ACC_W_MAX-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/soml_sq_stage.sv
// rtl/soml_sq_stage.sv - registered square stage: sq = (x*x) >> FRAC with valid/last
module soml_sq_stage
    import soml_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int FW = FRAC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic                  in_last_i,
    input  logic [DW-1:0]         in_r_i,
    output logic                  sq_valid_o,
    output logic                  sq_last_o,
    output logic [2*DW-FW-1:0]    sq_o
);

    logic signed [2*DW-1:0] in_ext;
    logic signed [2*DW-1:0] prod;
    logic                   prod_lo_unused;

    assign in_ext         = {{DW{in_r_i[DW-1]}}, in_r_i};
    assign prod           = in_ext * in_ext;
    assign prod_lo_unused = ^prod[FW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_valid_o <= 1'b0;
            sq_last_o  <= 1'b0;
            sq_o       <= '0;
        end else if (flush_i) begin
            sq_valid_o <= 1'b0;
            sq_last_o  <= 1'b0;
            sq_o       <= '0;
        end else begin
            sq_valid_o <= in_valid_i;
            sq_last_o  <= in_valid_i & in_last_i;
            sq_o       <= prod[2*DW-1:FW];
        end
    end

endmodule

// File: rtl/soml_metric_argmin.sv
// rtl/soml_metric_argmin.sv - per-candidate squared metric accumulation and argmin search; SOML_TIE_LAST_EN makes ties pick the later candidate
module soml_metric_argmin
    import soml_pkg::*;
#(
    parameter int DATA_W   = soml_pkg::DATA_W,
    parameter int FRAC     = soml_pkg::FRAC,
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = 4,
    parameter int ACC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [DATA_W-1:0]  in_r,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [ACC_W-1:0]   best_metric,
    output logic [IDX_W-1:0]   cand_cnt
);

    localparam int SQ_W  = 2*DATA_W - FRAC;
    localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam logic [ACC_W-1:0] ACC_SAT  = ACC_MAX[ACC_W-1:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t             state_q;
    logic               in_ready_q, busy_q, done_q;
    logic [IDX_W-1:0]   cand_q, best_idx_q;
    logic [ACC_W-1:0]   acc_q, acc_d, best_metric_q;
    logic [SUM_W-1:0]   acc_sum;
    logic               accept, sq_valid, sq_last, better;
    logic [SQ_W-1:0]    sq;

    assign accept = in_valid & in_ready_q;

    soml_sq_stage #(
        .DW (DATA_W),
        .FW (FRAC)
    ) u_sq (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (start),
        .in_valid_i (accept),
        .in_last_i  (in_last),
        .in_r_i     (in_r),
        .sq_valid_o (sq_valid),
        .sq_last_o  (sq_last),
        .sq_o       (sq)
    );

    // Sum is one bit wider than either operand so saturation never sees a wrapped value.
    assign acc_sum = SUM_W'(acc_q) + SUM_W'(sq);
    assign acc_d   = (acc_sum > SUM_W'(ACC_SAT)) ? ACC_SAT : acc_sum[ACC_W-1:0];

`ifdef SOML_TIE_LAST_EN
    assign better = (acc_q <= best_metric_q);
`else
    assign better = (acc_q < best_metric_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cand_q        <= '0;
            best_idx_q    <= '0;
            best_metric_q <= '0;
            acc_q         <= '0;
        end else if (start) begin
            state_q       <= ACCUM;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            cand_q        <= '0;
            best_idx_q    <= '0;
            best_metric_q <= '0;
            acc_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                end
                ACCUM: begin
                    if (sq_valid) begin
                        acc_q <= acc_d;
                    end
                    if (sq_valid && sq_last) begin
                        state_q    <= COMPARE;
                        in_ready_q <= 1'b0;
                    end else if (accept && in_last) begin
                        in_ready_q <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (cand_q == '0 || better) begin
                        best_idx_q    <= cand_q;
                        best_metric_q <= acc_q;
                    end
                    acc_q <= '0;
                    if (cand_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ACCUM;
                        cand_q     <= cand_q + 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_idx    = best_idx_q;
    assign best_metric = best_metric_q;
    assign cand_cnt    = cand_q;

endmodule
